// File: rtl/alu_pkg.sv
// Shared definitions for the two-requester bitwise logic arbiter.
// Contents: opcode constants for the logic unit and the output-slot state encoding.
package alu_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOT = 2'b11;

    // Output slot: StIdle holds no result, StFull holds one result awaiting out_ready.
    typedef enum logic {
        StIdle = 1'b0,
        StFull = 1'b1
    } state_e;

endpackage

// File: rtl/alu_logic_unit.sv
// Purely combinational WIDTH-bit bitwise logic unit.
// Ports:
//   op     - opcode (OP_AND, OP_OR, OP_XOR, OP_NOT)
//   x, y   - operands; y is ignored for OP_NOT
//   result - bitwise result, no carries between bits
module alu_logic_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = x & y;
            OP_OR:   result = x | y;
            OP_XOR:  result = x ^ y;
            OP_NOT:  result = ~x;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Two requesters share one bitwise logic unit; the granted request's result is
// registered into a single output slot with a valid/ready handshake.
// Build option: define ALU_LOGIC_ARB_RR_EN for round-robin arbitration; otherwise
// requester 0 has fixed priority and no pointer register exists.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   req_valid / req_ready     - per-requester handshake (index 0, 1)
//   req{0,1}_op, _x, _y       - per-requester opcode and operands
//   out_valid / out_ready     - result handshake
//   out_data, out_id          - registered result and the index of its requester
module alu_logic_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_x,
    input  logic [WIDTH-1:0] req0_y,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_x,
    input  logic [WIDTH-1:0] req1_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_id
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             id_q, id_d;

    logic             slot_free;
    logic             gnt_idx;
    logic             accept;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_x, alu_y, alu_result;

`ifdef ALU_LOGIC_ARB_RR_EN
    // Index of the requester that currently has priority.
    logic ptr_q, ptr_d;
`endif

    assign slot_free = (state_q == StIdle) || out_ready;

    // Winner is chosen from req_valid alone; gnt_idx only matters when some request is valid.
    always_comb begin
        gnt_idx = 1'b0;
`ifdef ALU_LOGIC_ARB_RR_EN
        if (req_valid[ptr_q]) begin
            gnt_idx = ptr_q;
        end else begin
            gnt_idx = ~ptr_q;
        end
`else
        gnt_idx = req_valid[0] ? 1'b0 : 1'b1;
`endif
    end

    always_comb begin
        req_ready = 2'b00;
        if (rst_n && slot_free && (req_valid != 2'b00)) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    always_comb begin
        alu_op = gnt_idx ? req1_op : req0_op;
        alu_x  = gnt_idx ? req1_x  : req0_x;
        alu_y  = gnt_idx ? req1_y  : req0_y;
    end

    alu_logic_unit #(
        .WIDTH (WIDTH)
    ) u_unit (
        .op     (alu_op),
        .x      (alu_x),
        .y      (alu_y),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
`ifdef ALU_LOGIC_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        if (accept) begin
            state_d = StFull;
            data_d  = alu_result;
            id_d    = gnt_idx;
`ifdef ALU_LOGIC_ARB_RR_EN
            ptr_d   = ~gnt_idx;
`endif
        end else if (out_ready) begin
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '0;
            id_q    <= 1'b0;
`ifdef ALU_LOGIC_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            id_q    <= id_d;
`ifdef ALU_LOGIC_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign out_id    = id_q;

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Directed self-checking bench for alu_logic_arbiter (WIDTH=4). Expected values
// follow the build option ALU_LOGIC_ARB_RR_EN where arbitration matters.
module tb_alu_logic_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_x, req0_y, req1_x, req1_y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       out_id;

    int n_tests = 0;
    int n_fail  = 0;

    alu_logic_arbiter #(
        .WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_op   (req0_op),
        .req0_x    (req0_x),
        .req0_y    (req0_y),
        .req1_op   (req1_op),
        .req1_x    (req1_x),
        .req1_y    (req1_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; out_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL reset_ready: got %b want 00", req_ready);
        end
        step();
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b d=%b id=%b want v=0 d=0000 id=0",
                     out_valid, out_data, out_id);
        end
        req_valid = 2'b00;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        req_valid = 2'b01; req0_op = 2'b00; req0_x = 4'b1100; req0_y = 4'b1010; out_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL basic_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'b1000 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_and: got v=%b d=%b id=%b want v=1 d=1000 id=0",
                     out_valid, out_data, out_id);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_drain: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_ops();
        logic [1:0] ops   [3] = '{2'b11, 2'b10, 2'b01};
        logic [3:0] xs    [3] = '{4'b0101, 4'b1111, 4'b0001};
        logic [3:0] ys    [3] = '{4'b1111, 4'b0110, 4'b1000};
        logic [3:0] exps  [3] = '{4'b1010, 4'b1001, 4'b1001};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b10; req1_op = ops[i]; req1_x = xs[i]; req1_y = ys[i];
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== exps[i] || out_id !== 1'b1) begin
                n_fail++;
                $display("FAIL ops_%0d: got v=%b d=%b id=%b want v=1 d=%b id=1",
                         i, out_valid, out_data, out_id, exps[i]);
            end
        end
        req_valid = 2'b00;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL ops_drain: got v=%b want 0", out_valid);
        end
    endtask

    // Pointer here is 0 under round-robin: last acceptance was requester 1.
    task automatic test_back_to_back();
        logic       exp_id;
        logic [3:0] exp_d;
        req_valid = 2'b11; out_ready = 1'b1;
        req0_op = 2'b00; req0_x = 4'b1111; req0_y = 4'b0011;  // AND -> 0011
        req1_op = 2'b10; req1_x = 4'b1111; req1_y = 4'b0011;  // XOR -> 1100
        for (int i = 0; i < 4; i++) begin
`ifdef ALU_LOGIC_ARB_RR_EN
            exp_id = i[0];
`else
            exp_id = 1'b0;
`endif
            exp_d = exp_id ? 4'b1100 : 4'b0011;
            #1;
            n_tests++;
            if (req_ready !== (exp_id ? 2'b10 : 2'b01)) begin
                n_fail++; $display("FAIL b2b_ready_%0d: got %b want id %b", i, req_ready, exp_id);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_id !== exp_id || out_data !== exp_d) begin
                n_fail++;
                $display("FAIL b2b_%0d: got v=%b d=%b id=%b want v=1 d=%b id=%b",
                         i, out_valid, out_data, out_id, exp_d, exp_id);
            end
        end
    endtask

    task automatic test_stall();
        logic       hold_id;
        logic [3:0] hold_d;
`ifdef ALU_LOGIC_ARB_RR_EN
        hold_id = 1'b1; hold_d = 4'b1100;
`else
        hold_id = 1'b0; hold_d = 4'b0011;
`endif
        out_ready = 1'b0;
        req_valid = 2'b11;
        req0_op = 2'b01; req0_x = 4'b0100; req0_y = 4'b0001;  // OR -> 0101
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (req_ready !== 2'b00) begin
                n_fail++; $display("FAIL stall_ready_%0d: got %b want 00", i, req_ready);
            end
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== hold_d || out_id !== hold_id) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got v=%b d=%b id=%b want v=1 d=%b id=%b",
                         i, out_valid, out_data, out_id, hold_d, hold_id);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL stall_release_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'b0101 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_release: got v=%b d=%b id=%b want v=1 d=0101 id=0",
                     out_valid, out_data, out_id);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_drain: got v=%b want 0", out_valid);
        end
    endtask

    // Requester 0 wins before reset, so a live round-robin pointer would favour 1.
    task automatic test_reset_full();
        out_ready = 1'b1;
        req_valid = 2'b01; req0_op = 2'b10; req0_x = 4'b1010; req0_y = 4'b0110;  // XOR -> 1100
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'b1100) begin
            n_fail++; $display("FAIL rf_fill: got v=%b d=%b want v=1 d=1100", out_valid, out_data);
        end
        req_valid = 2'b11;
        req1_op = 2'b11; req1_x = 4'b0000; req1_y = 4'b0000;  // NOT -> 1111
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 2'b00) begin
            n_fail++; $display("FAIL rf_ready_in_reset: got %b want 00", req_ready);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rf_flush: got v=%b d=%b id=%b want v=0 d=0000 id=0",
                     out_valid, out_data, out_id);
        end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 2'b01) begin
            n_fail++; $display("FAIL rf_post_ready: got %b want 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 4'b1100 || out_id !== 1'b0) begin
            n_fail++;
            $display("FAIL rf_post_win: got v=%b d=%b id=%b want v=1 d=1100 id=0",
                     out_valid, out_data, out_id);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 2'b00; out_ready = 1'b0;
        req0_op = 2'b00; req0_x = '0; req0_y = '0;
        req1_op = 2'b00; req1_x = '0; req1_y = '0;
        test_reset();
        test_basic();
        test_ops();
        test_back_to_back();
        test_stall();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
ALU_LOGIC_ARBITER -- requirements
Module: alu_logic_arbiter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have ports req_valid, input, 2 bits: per-requester (0, 1) request valid.
REQ-005 The block SHALL have ports req_ready, output, 2 bits: per-requester accept; a request is accepted when req_valid[i] and req_ready[i] are both high.
REQ-006 The block SHALL have ports req0_op, req1_op, input, 2 bits each: opcode, with 00=AND, 01=OR, 10=XOR, 11=NOT x.
REQ-007 The block SHALL have ports req0_x, req0_y, req1_x, req1_y, input, WIDTH each: operands.
REQ-008 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accept.
REQ-010 The block SHALL have port out_data, output, WIDTH: registered result.
REQ-011 The block SHALL have port out_id, output, 1 bit: index of the requester that owns out_data.

Function
REQ-012 The block SHALL share one combinational WIDTH-bit logic unit between two requesters.
REQ-013 The block SHALL implement two states:
- IDLE: out_valid=0.
- FULL: out_valid=1.
REQ-014 The output slot SHALL be free when state==IDLE or out_ready==1.
REQ-015 The grant SHALL be computed combinationally from req_valid and the priority pointer, and exactly one req_ready bit SHALL be high when the slot is free and any req_valid is high; otherwise both SHALL be 0.
REQ-016 req_ready SHALL NOT depend on the requester's own req_valid other than through the arbitration.
REQ-017 On acceptance, the block SHALL register out_data=f(op,x,y), set out_id=granted index and enter FULL on the next edge: latency 1 cycle.
REQ-018 In FULL with out_ready=1 and no new acceptance, the block SHALL return to IDLE.
REQ-019 In FULL with out_ready=1 and a simultaneous acceptance, the block SHALL stay in FULL and load the new result (back-to-back, one result per cycle).
REQ-020 In FULL with out_ready=0, out_data and out_id SHALL hold stable and req_ready SHALL be 2'b00.
REQ-021 Operations SHALL be bitwise over all WIDTH bits with no carry; NOT SHALL ignore y.
REQ-022 Requests that are not accepted SHALL not be buffered; a requester holds its inputs until accepted.

Reset
REQ-023 With rst_n=0 at a rising edge, the block SHALL set state=IDLE, out_valid=0, out_data=0, out_id=0 and the priority pointer to requester 0.
REQ-024 Reset SHALL override any acceptance or out_ready in the same cycle; an in-flight result SHALL be discarded.
REQ-025 req_ready SHALL be 2'b00 while rst_n=0.

Configuration
REQ-026 Arbitration SHALL be controlled by the macro ALU_LOGIC_ARB_RR_EN.
- Defined: round-robin; after each acceptance the pointer SHALL move so that the other requester has priority next.
- Undefined: fixed priority; requester 0 SHALL always win, and the pointer register SHALL be absent.

Structure
REQ-027 The opcode constants (OP_AND, OP_OR, OP_XOR, OP_NOT) and the state encoding SHALL live in the shared package alu_pkg.
REQ-028 The bitwise datapath SHALL be a sub-module alu_logic_unit (inputs op, x, y; output result; purely combinational), instantiated once.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset, then req_valid=01, op=AND, x=1100, y=1010, out_ready=1 -> next cycle out_valid=1, out_data=1000, out_id=0.
- Both requesters hold valid continuously, out_ready=1, RR_EN defined -> out_id alternates 0,1,0,1, one result per cycle. Without RR_EN -> out_id stays 0 and req_ready[1] never rises.
- FULL with out_ready=0 for 3 cycles -> out_data/out_id stable and req_ready=00; then out_ready=1 -> same-cycle acceptance, new result on the next edge.
- req1 op=NOT, x=0101, y=1111 -> out_data=1010, out_id=1; op=XOR, x=1111, y=0110 -> 1001; op=OR, x=0001, y=1000 -> 1001.
- rst_n=0 asserted while FULL and a request is valid -> next cycle out_valid=0, out_data=0, pointer reset so requester 0 wins the first post-reset contention.
